// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: forwarding selects and stall/flush control for the
// 5-stage MIPS pipeline. Forward selects are purely combinational. A small
// two-state FSM tracks multi-cycle mult/div occupancy in the execute stage.
// Optional build macro: HAZ_STAT_EN adds saturating 16-bit stall-cause counters
// (LoadStallCnt, BranchStallCnt, MdStallCnt).
module hazard_forward_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int REG_AW     = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic              BranchD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MdStartE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MdBusy
`ifdef HAZ_STAT_EN
    ,
    output logic [15:0]       LoadStallCnt,
    output logic [15:0]       BranchStallCnt,
    output logic [15:0]       MdStallCnt
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);

    md_state_t  state, state_next;
    logic [3:0] md_cnt, md_cnt_next;

    // Per-stage "valid writer" qualifiers: register 0 never produces a hazard.
    logic wr_e, wr_m, wr_w;
    assign wr_e = RegWriteE && (WriteRegE != '0);
    assign wr_m = RegWriteM && (WriteRegM != '0);
    assign wr_w = RegWriteW && (WriteRegW != '0);

    logic lwstall, brstall, md_active;

    // Execute-stage operand forwarding: M stage has priority over W stage.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        ForwardAE = 2'd0;
        ForwardBE = 2'd0;
        if (wr_m && (WriteRegM == RsE))      ForwardAE = 2'd2;
        else if (wr_w && (WriteRegW == RsE)) ForwardAE = 2'd1;
        if (wr_m && (WriteRegM == RtE))      ForwardBE = 2'd2;
        else if (wr_w && (WriteRegW == RtE)) ForwardBE = 2'd1;
    end

    // Decode-stage branch comparator forwarding and hazard detection.
    always_comb begin
        ForwardAD = wr_m && (WriteRegM == RsD);
        ForwardBD = wr_m && (WriteRegM == RtD);
        lwstall   = MemtoRegE && wr_e && ((WriteRegE == RsD) || (WriteRegE == RtD));
        brstall   = BranchD &&
                    ((wr_e && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                     (MemtoRegM && wr_m && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    end

    // Mult/div occupancy FSM: state register with synchronous reset.
    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!Rst_n) begin
            state  <= IDLE;
            md_cnt <= 4'd0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // Mult/div occupancy FSM: next-state and counter; MdStartE ignored while busy.
    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        unique case (state)
            IDLE: begin
                if (MdStartE) begin
                    state_next  = MD_BUSY;
                    md_cnt_next = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt == 4'd0) state_next  = IDLE;
                else                md_cnt_next = md_cnt - 4'd1;
            end
            default: begin
                state_next  = IDLE;
                md_cnt_next = 4'd0;
            end
        endcase
    end

    assign md_active = (state == MD_BUSY) || MdStartE;

    // Stall/flush outputs: mult/div occupancy masks load-use and branch stalls.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        MdBusy = 1'b0;
        if (md_active) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            MdBusy = 1'b1;
        end else begin
            StallF = lwstall | brstall;
            StallD = lwstall | brstall;
            FlushE = lwstall | brstall;
        end
    end

`ifdef HAZ_STAT_EN
    // Saturating stall-cause counters; a combined load/branch stall counts as load.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            LoadStallCnt   <= 16'd0;
            BranchStallCnt <= 16'd0;
            MdStallCnt     <= 16'd0;
        end else begin
            if (md_active) begin
                if (MdStallCnt != 16'hFFFF) MdStallCnt <= MdStallCnt + 16'd1;
            end else if (lwstall) begin
                if (LoadStallCnt != 16'hFFFF) LoadStallCnt <= LoadStallCnt + 16'd1;
            end else if (brstall) begin
                if (BranchStallCnt != 16'hFFFF) BranchStallCnt <= BranchStallCnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed self-checking bench for hazard_forward_ctrl (MD_LATENCY = 4).
module tb_hazard_forward_ctrl;

    localparam int MD_LATENCY = 4;
    localparam int REG_AW     = 5;

    logic              Clk, Rst_n;
    logic [REG_AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic              BranchD, RegWriteE, MemtoRegE, MdStartE;
    logic              RegWriteM, MemtoRegM, RegWriteW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              ForwardAD, ForwardBD;
    logic              StallF, StallD, StallE, FlushE, FlushM, MdBusy;
`ifdef HAZ_STAT_EN
    logic [15:0]       LoadStallCnt, BranchStallCnt, MdStallCnt;
`endif

    int total = 0;
    int bad   = 0;

    hazard_forward_ctrl #(.MD_LATENCY(MD_LATENCY), .REG_AW(REG_AW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MdStartE(MdStartE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushE(FlushE), .FlushM(FlushM), .MdBusy(MdBusy)
`ifdef HAZ_STAT_EN
        ,
        .LoadStallCnt(LoadStallCnt), .BranchStallCnt(BranchStallCnt),
        .MdStallCnt(MdStallCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stall/flush/busy vector packed as {StallF,StallD,StallE,FlushE,FlushM,MdBusy}.
    function automatic logic [15:0] ctl();
        return {10'd0, StallF, StallD, StallE, FlushE, FlushM, MdBusy};
    endfunction

    task automatic clear_inputs();
        RsD = '0; RtD = '0; BranchD = 0; RsE = '0; RtE = '0;
        WriteRegE = '0; RegWriteE = 0; MemtoRegE = 0; MdStartE = 0;
        WriteRegM = '0; RegWriteM = 0; MemtoRegM = 0;
        WriteRegW = '0; RegWriteW = 0;
    endtask

    // Advance past the next rising edge; inputs are then changed mid-cycle.
    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    localparam logic [15:0] CTL_IDLE = 16'b000000;
    localparam logic [15:0] CTL_HAZ  = 16'b110100;
    localparam logic [15:0] CTL_MD   = 16'b111011;

    initial begin
        clear_inputs();
        Rst_n = 0;
        cyc();
        cyc();
        Rst_n = 1;
        #1 check("reset_ctl", ctl(), CTL_IDLE);

        // Forwarding from M.
        RegWriteM = 1; WriteRegM = 5'd3; RsE = 5'd3; RtE = 5'd3;
        #1 check("fwd_m_a", 16'(ForwardAE), 16'd2);
        check("fwd_m_b", 16'(ForwardBE), 16'd2);
        WriteRegM = 5'd0;
        #1 check("fwd_r0_a", 16'(ForwardAE), 16'd0);
        check("fwd_r0_b", 16'(ForwardBE), 16'd0);

        // M priority over W, then W alone.
        clear_inputs();
        RegWriteM = 1; WriteRegM = 5'd5; RegWriteW = 1; WriteRegW = 5'd5; RsE = 5'd5; RtE = 5'd6;
        #1 check("fwd_prio_a", 16'(ForwardAE), 16'd2);
        check("fwd_prio_b", 16'(ForwardBE), 16'd0);
        RegWriteM = 0;
        #1 check("fwd_w_a", 16'(ForwardAE), 16'd1);
        RegWriteW = 0;
        #1 check("fwd_none_a", 16'(ForwardAE), 16'd0);

        // Load-use hazard, one cycle, then the load advances to M.
        clear_inputs();
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5'd4; RtD = 5'd4;
        #1 check("lw_stall", ctl(), CTL_HAZ);
        cyc();
        MemtoRegE = 0; RegWriteE = 0; WriteRegE = '0;
        MemtoRegM = 1; RegWriteM = 1; WriteRegM = 5'd4;
        #1 check("lw_after", ctl(), CTL_IDLE);
        check("lw_fwd_bd", 16'(ForwardBD), 16'd1);
        clear_inputs();
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5'd0; RsD = 5'd0;
        #1 check("lw_r0", ctl(), CTL_IDLE);

        // Branch on an ALU result in E, then forward from M.
        clear_inputs();
        BranchD = 1; RsD = 5'd7; RtD = 5'd1; RegWriteE = 1; WriteRegE = 5'd7;
        #1 check("br_stall", ctl(), CTL_HAZ);
        cyc();
        RegWriteE = 0; WriteRegE = '0; RegWriteM = 1; WriteRegM = 5'd7;
        #1 check("br_after", ctl(), CTL_IDLE);
        check("br_fwd_ad", 16'(ForwardAD), 16'd1);
        check("br_fwd_bd", 16'(ForwardBD), 16'd0);
        MemtoRegM = 1;
        #1 check("br_load_m", ctl(), CTL_HAZ);
        // Load-use and branch hazard together: still a single stall.
        MemtoRegM = 0; RegWriteM = 0;
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5'd1;
        #1 check("lw_br_both", ctl(), CTL_HAZ);

        // Mult/div occupancy: start cycle plus MD_LATENCY-1 busy cycles.
        clear_inputs();
        MdStartE = 1;
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5'd2; RsD = 5'd2;  // masked lwstall
        #1 check("md_start", ctl(), CTL_MD);
        cyc();
        MdStartE = 0;
        #1 check("md_busy1", ctl(), CTL_MD);
        cyc();
        MdStartE = 1;  // ignored while busy
        #1 check("md_busy2", ctl(), CTL_MD);
        cyc();
        MdStartE = 0;
        #1 check("md_busy3", ctl(), CTL_MD);
        cyc();
        #1 check("md_done_lw", ctl(), CTL_HAZ);
        clear_inputs();
        #1 check("md_done", ctl(), CTL_IDLE);
        cyc();
        #1 check("md_no_restart", ctl(), CTL_IDLE);

        // Reset in the second busy cycle.
        MdStartE = 1;
        cyc();
        MdStartE = 0;
        cyc();
        #1 check("rst_pre", ctl(), CTL_MD);
        Rst_n = 0;
        cyc();
        Rst_n = 1;
        #1 check("rst_mid_busy", ctl(), CTL_IDLE);
`ifdef HAZ_STAT_EN
        check("rst_md_cnt", MdStallCnt, 16'd0);
`endif
        cyc();
        #1 check("rst_stays_idle", ctl(), CTL_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Central hazard controller for the 5-stage pipelined MIPS core. It generates the per-operand forwarding selects that drive the execute-stage operand muxes and the decode-stage branch comparator. It also produces the stall and flush controls for load-use hazards, branch-operand hazards and multi-cycle multiply/divide occupancy. It sits beside the pipeline registers and observes register numbers and control bits from the D, E, M and W stages.

Parameters:
MD_LATENCY, 4, total execute-stage cycles a mult/div occupies (legal range 2..15)
REG_AW, 5, register-number width

Ports:
Clk  in  1  pipeline clock; all state updates on rising edge
Rst_n  in  1  synchronous active-low reset, sampled on rising edge of Clk
RsD  in  REG_AW  decode-stage source register A
RtD  in  REG_AW  decode-stage source register B
BranchD  in  1  decode-stage instruction is beq/bne
RsE  in  REG_AW  execute-stage source register A
RtE  in  REG_AW  execute-stage source register B
WriteRegE  in  REG_AW  execute-stage destination register
RegWriteE  in  1  execute-stage instruction writes the register file
MemtoRegE  in  1  execute-stage instruction is a load
MdStartE  in  1  execute-stage instruction is mult/div, first E cycle
WriteRegM  in  REG_AW  memory-stage destination register
RegWriteM  in  1  memory-stage register write
MemtoRegM  in  1  memory-stage load
WriteRegW  in  REG_AW  writeback-stage destination register
RegWriteW  in  1  writeback-stage register write
ForwardAE  out  2  operand A select: 0 = register file, 1 = ResultW, 2 = ALUOutM
ForwardBE  out  2  operand B select, same encoding
ForwardAD  out  1  branch comparator A takes ALUOutM
ForwardBD  out  1  branch comparator B takes ALUOutM
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
FlushE  out  1  clear ID/EX register (insert bubble)
FlushM  out  1  clear EX/MEM register
MdBusy  out  1  mult/div occupancy in progress

Behaviour:
- Register 0 is never a forwarding or hazard source. Every match requires a nonzero destination and an asserted RegWrite of that stage.
- ForwardAE (combinational):
  - 2 if RegWriteM and WriteRegM == RsE.
  - Otherwise 1 if RegWriteW and WriteRegW == RsE.
  - Otherwise 0.
  - M has priority over W. ForwardBE is identical using RtE.
- ForwardAD = RegWriteM && WriteRegM == RsD. ForwardBD is the same using RtD.
- lwstall = MemtoRegE && (WriteRegE == RsD || WriteRegE == RtD).
- brstall = BranchD && ((RegWriteE && WriteRegE matches RsD or RtD) || (MemtoRegM && WriteRegM matches RsD or RtD)).
- State machine, states IDLE and MD_BUSY, with a 4-bit down-counter:
  - IDLE -> MD_BUSY when MdStartE = 1. Counter loads MD_LATENCY-2.
  - In MD_BUSY, counter decrements each cycle. Return to IDLE on the cycle after the counter reaches 0.
  - Stall therefore spans exactly MD_LATENCY-1 cycles after the start cycle.
  - MdStartE is ignored while in MD_BUSY.
- Outputs in MD_BUSY, or in IDLE with MdStartE = 1:
  - StallF = StallD = StallE = 1, FlushM = 1, FlushE = 0.
  - MdBusy = 1.
  - lwstall and brstall are masked; they re-evaluate once back in IDLE.
- Outputs in IDLE otherwise:
  - StallF = StallD = FlushE = lwstall | brstall.
  - StallE = FlushM = 0, MdBusy = 0.
- Reset (Rst_n = 0 at an edge):
  - State goes to IDLE, counter to 0, even mid-busy.
  - Stall and flush outputs read 0 in the cycle after the reset edge. Forward outputs remain purely combinational.
- Simultaneous lwstall and brstall: a single stall; no extra cycle.

Optional Feature:
HAZ_STAT_EN
- Defined: adds three 16-bit outputs, LoadStallCnt, BranchStallCnt and MdStallCnt.
  - Each increments on every cycle in which its cause produced a stall.
  - For a cycle where lwstall and brstall are both true, only LoadStallCnt increments.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- add $3 in M (RegWriteM = 1, WriteRegM = 3), RsE = 3, RtE = 3 -> ForwardAE = 2, ForwardBE = 2; same with WriteRegM = 0 -> both 0.
- WriteRegM = 5 and WriteRegW = 5 both writing, RsE = 5 -> ForwardAE = 2 (M priority); drop RegWriteM -> ForwardAE = 1.
- lw $4 in E (MemtoRegE = 1, RegWriteE = 1, WriteRegE = 4), RtD = 4 -> StallF = StallD = FlushE = 1 for exactly one cycle, then 0 once the load advances.
- beq RsD = 7 with RegWriteE, WriteRegE = 7 -> brstall one cycle; next cycle RegWriteM, WriteRegM = 7 (not load) -> ForwardAD = 1 and no stall.
- MdStartE pulse, MD_LATENCY = 4 -> MdBusy, StallF/D/E and FlushM high on the start cycle plus 3 more (4 total), then low; a second MdStartE during busy has no effect.
- Assert Rst_n = 0 in the 2nd busy cycle -> next cycle all stalls 0 and state IDLE; with HAZ_STAT_EN, MdStallCnt reads 0.
